// File: rtl/mod_inverse.sv
// Iterative modular inverter: binary extended Euclid, one reduction step per clock.
// x1/x2 carry one extra bit so the (x + q) halving sum never overflows.
`ifndef D_width
`define D_width 16
`endif

module mod_inverse #(
  parameter int DATA_WIDTH = `D_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] A_in,
  input  logic [DATA_WIDTH-1:0] modulus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] result
);
  localparam int W = DATA_WIDTH;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t       r_state, w_state_nxt;
  logic         r_first;
  logic [W-1:0] r_u, r_v, r_q;
  logic [W:0]   r_x1, r_x2;
  logic         r_done, r_err;
  logic [W-1:0] r_result;

  logic         w_illegal, w_accept, w_reject, w_step;
  logic         w_fin_x1, w_fin_x2, w_fin_gcd, w_finish;
  logic [W:0]   w_q_ext, w_x1_half, w_x2_half, w_x1_sub, w_x2_sub;
  logic         w_done_nxt, w_err_nxt;
  logic [W-1:0] w_result_nxt, w_u_nxt, w_v_nxt;
  logic [W:0]   w_x1_nxt, w_x2_nxt;

  assign w_illegal = (A_in == '0) || !modulus[0] || (modulus < W'(3)) || (A_in >= modulus);
  assign w_accept  = (r_state == S_IDLE) && start && !w_illegal;
  assign w_reject  = (r_state == S_IDLE) && start && w_illegal;
  // The first RUN cycle only settles the freshly loaded operands.
  assign w_step    = (r_state == S_RUN) && !r_first;

  assign w_fin_x1  = (r_u == W'(1));
  assign w_fin_x2  = (r_v == W'(1));
  assign w_fin_gcd = (r_u == '0) || (r_v == '0);
  assign w_finish  = w_step && (w_fin_x1 || w_fin_x2 || w_fin_gcd);

  assign w_q_ext   = {1'b0, r_q};
  assign w_x1_half = r_x1[0] ? ((r_x1 + w_q_ext) >> 1) : (r_x1 >> 1);
  assign w_x2_half = r_x2[0] ? ((r_x2 + w_q_ext) >> 1) : (r_x2 >> 1);
  assign w_x1_sub  = (r_x1 >= r_x2) ? (r_x1 - r_x2) : (r_x1 + w_q_ext - r_x2);
  assign w_x2_sub  = (r_x2 >= r_x1) ? (r_x2 - r_x1) : (r_x2 + w_q_ext - r_x1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RUN;
      S_RUN:  if (w_finish) w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_done_nxt   = 1'b0;
    w_err_nxt    = r_err;
    w_result_nxt = r_result;
    w_u_nxt      = r_u;
    w_v_nxt      = r_v;
    w_x1_nxt     = r_x1;
    w_x2_nxt     = r_x2;
    if (w_reject) begin
      w_done_nxt   = 1'b1;
      w_err_nxt    = 1'b1;
      w_result_nxt = '0;
    end else if (w_accept) begin
      w_u_nxt  = A_in;
      w_v_nxt  = modulus;
      w_x1_nxt = (W+1)'(1);
      w_x2_nxt = '0;
    end else if (w_step) begin
      if (w_fin_x1) begin
        w_done_nxt   = 1'b1;
        w_err_nxt    = 1'b0;
        w_result_nxt = r_x1[W-1:0];
      end else if (w_fin_x2) begin
        w_done_nxt   = 1'b1;
        w_err_nxt    = 1'b0;
        w_result_nxt = r_x2[W-1:0];
      end else if (w_fin_gcd) begin
        w_done_nxt   = 1'b1;
        w_err_nxt    = 1'b1;
        w_result_nxt = '0;
      end else if (!r_u[0]) begin
        w_u_nxt  = r_u >> 1;
        w_x1_nxt = w_x1_half;
      end else if (!r_v[0]) begin
        w_v_nxt  = r_v >> 1;
        w_x2_nxt = w_x2_half;
      end else if (r_u >= r_v) begin
        w_u_nxt  = r_u - r_v;
        w_x1_nxt = w_x1_sub;
      end else begin
        w_v_nxt  = r_v - r_u;
        w_x2_nxt = w_x2_sub;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_first  <= 1'b0;
      r_u      <= '0;
      r_v      <= '0;
      r_q      <= '0;
      r_x1     <= '0;
      r_x2     <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_first  <= w_accept;
      r_u      <= w_u_nxt;
      r_v      <= w_v_nxt;
      r_x1     <= w_x1_nxt;
      r_x2     <= w_x2_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_result <= w_result_nxt;
      if (w_accept) r_q <= modulus;
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = r_done;
  assign err    = r_err;
  assign result = r_result;

endmodule
